iter_mul_unit: RTL and testbench

Parametrised sequential shift-add multiplier for the processor datapath. It replaces the 8-bit combinational, truncating multiply with a multi-cycle unit. The unit returns the full 2*WIDTH-bit product, supports signed or unsigned operands per operation, and has a START/BUSY/DONE handshake. The control unit stalls PC update while BUSY is high and writes back on DONE.

---
 rtl/iter_mul_unit.sv | 139 +++++++++++++
 tb/tb_iter_mul_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iter_mul_unit.sv
// iter_mul_unit: sequential shift-add multiplier with START/BUSY/DONE handshake.
//
// Produces the full 2*WIDTH-bit product of two WIDTH-bit operands, either unsigned or
// two's-complement (selected per operation). Operands are converted to magnitudes on
// accept, multiplied with one shift-add step per cycle for exactly WIDTH cycles, and
// the sign is re-applied on the final step.
//
// Ports:
//   CLK          clock, rising edge
//   RESET        synchronous active-high reset, highest priority
//   START        request a new multiply (accepted only when idle)
//   SIGNED_MODE  1 = signed operands, 0 = unsigned; sampled with START
//   DATA1        multiplicand; sampled with START
//   DATA2        multiplier; sampled with START
//   BUSY         operation in progress; STARTs are ignored
//   DONE         one-cycle pulse when RESULT_HI/RESULT_LO/ZERO update
//   RESULT_HI    upper half of the product
//   RESULT_LO    lower half of the product
//   ZERO         full product equals zero
module iter_mul_unit #(
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SIGNED_MODE,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic [WIDTH-1:0] RESULT_LO,
    output logic             ZERO
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;   // multiplicand magnitude, pre-shifted by the iteration index
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic [PW-1:0]    r_res;
    logic             r_zero;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [PW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_prod;

    assign w_accept = (r_state == IDLE) && START;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(1));

    assign w_s1 = SIGNED_MODE & DATA1[WIDTH-1];
    assign w_s2 = SIGNED_MODE & DATA2[WIDTH-1];

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    assign w_mag1 = w_s1 ? (~DATA1 + WIDTH'(1)) : DATA1;
    assign w_mag2 = w_s2 ? (~DATA2 + WIDTH'(1)) : DATA2;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod    = r_neg ? (~w_acc_nxt + PW'(1)) : w_acc_nxt;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (START) w_state_nxt = RUN;
            RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        BUSY      = (r_state == RUN);
        DONE      = r_done;
        RESULT_HI = r_res[PW-1:WIDTH];
        RESULT_LO = r_res[WIDTH-1:0];
        ZERO      = r_zero;
    end

    // Datapath
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_res    <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_neg    <= w_s1 ^ w_s2;
                r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
                r_mplier <= w_mag2;
                r_acc    <= '0;
                r_cnt    <= CNT_W'(WIDTH);
            end else if (r_state == RUN) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_res  <= w_prod;
                    r_zero <= (w_prod == '0);
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_mul_unit.sv
module tb_iter_mul_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  d1_8 = '0, d2_8 = '0;
    logic        busy8, done8, zero8;
    logic [7:0]  hi8, lo8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] d1_16 = '0, d2_16 = '0;
    logic        busy16, done16, zero16;
    logic [15:0] hi16, lo16;

    iter_mul_unit #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .RESET(RESET), .START(start8), .SIGNED_MODE(sm8),
        .DATA1(d1_8), .DATA2(d2_8), .BUSY(busy8), .DONE(done8),
        .RESULT_HI(hi8), .RESULT_LO(lo8), .ZERO(zero8)
    );

    iter_mul_unit #(.WIDTH(16)) u_dut16 (
        .CLK(CLK), .RESET(RESET), .START(start16), .SIGNED_MODE(sm16),
        .DATA1(d1_16), .DATA2(d2_16), .BUSY(busy16), .DONE(done16),
        .RESULT_HI(hi16), .RESULT_LO(lo16), .ZERO(zero16)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {zero, product} and the cycle count at which DONE must be seen.
    logic [16:0] q8_res[$];
    int          q8_cyc[$];
    logic [32:0] q16_res[$];
    int          q16_cyc[$];

    bit chk_rst = 1'b0;
    bit fin_chk = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        bit          prev8 = 1'b0, prev16 = 1'b0;
        logic [16:0] e8;
        logic [32:0] e16;
        int          ec;
        forever begin
            @(negedge CLK);
            if (chk_rst) begin
                chk("rst_busy8", busy8, 0);
                chk("rst_done8", done8, 0);
                chk("rst_res8", {hi8, lo8}, 0);
                chk("rst_zero8", zero8, 0);
                chk("rst_busy16", busy16, 0);
                chk("rst_res16", {hi16, lo16, zero16, done16}, 0);
            end
            if (q8_res.size() > 0 && cyc < q8_cyc[0]) chk("busy8_run", busy8, 1);
            if (done8) begin
                if (prev8) chk("done8_twice", 1, 0);
                if (q8_res.size() == 0) begin
                    chk("unexpected_done8", 1, 0);
                end else begin
                    e8 = q8_res.pop_front();
                    ec = q8_cyc.pop_front();
                    chk("result8", {hi8, lo8}, e8[15:0]);
                    chk("zero8", zero8, e8[16]);
                    chk("latency8", cyc, ec);
                    chk("busy8_done", busy8, 0);
                end
            end
            if (q16_res.size() > 0 && cyc < q16_cyc[0]) chk("busy16_run", busy16, 1);
            if (done16) begin
                if (prev16) chk("done16_twice", 1, 0);
                if (q16_res.size() == 0) begin
                    chk("unexpected_done16", 1, 0);
                end else begin
                    e16 = q16_res.pop_front();
                    ec  = q16_cyc.pop_front();
                    chk("result16", {hi16, lo16}, e16[31:0]);
                    chk("zero16", zero16, e16[32]);
                    chk("latency16", cyc, ec);
                end
            end
            if (fin_chk) begin
                chk("pending8", q8_res.size(), 0);
                chk("pending16", q16_res.size(), 0);
            end
            prev8  = done8;
            prev16 = done16;
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive START for one edge; afterwards scramble operands to prove they were latched.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input bit push);
        start8 = 1'b1; d1_8 = a; d2_8 = b; sm8 = sm;
        ticks(1);
        start8 = 1'b0; d1_8 = ~a; d2_8 = ~b; sm8 = ~sm;
        if (push) begin
            q8_res.push_back({exp == 16'h0, exp});
            q8_cyc.push_back(cyc + 8);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic [31:0] exp);
        start16 = 1'b1; d1_16 = a; d2_16 = b; sm16 = sm;
        ticks(1);
        start16 = 1'b0; d1_16 = ~a; d2_16 = ~b; sm16 = ~sm;
        q16_res.push_back({exp == 32'h0, exp});
        q16_cyc.push_back(cyc + 16);
    endtask

    task automatic reset_pulse();
        RESET = 1'b1;
        ticks(1);
        RESET = 1'b0;
        chk_rst = 1'b1;
        @(negedge CLK);
        #1;
        chk_rst = 1'b0;
    endtask

    logic [7:0]  va[10] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h05, 8'h00, 8'h00, 8'h0C, 8'h7F, 8'h05};
    logic [7:0]  vb[10] = '{8'hFF, 8'hFF, 8'h80, 8'h01, 8'hFD, 8'hA7, 8'hA7, 8'h0D, 8'h80, 8'hFD};
    logic        vs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ve[10] = '{16'hFE01, 16'h0001, 16'h4000, 16'hFF80, 16'hFFF1,
                            16'h0000, 16'h0000, 16'h009C, 16'hC080, 16'h04F1};

    initial begin
        ticks(1);
        reset_pulse();

        for (int i = 0; i < 10; i++) begin
            op8(va[i], vb[i], vs[i], ve[i], 1'b1);
            ticks(10);
        end

        // START mid-RUN with other operands must be ignored
        op8(8'h03, 8'h04, 1'b0, 16'h000C, 1'b1);
        ticks(3);
        start8 = 1'b1; d1_8 = 8'hFF; d2_8 = 8'hFF; sm8 = 1'b1;
        ticks(1);
        start8 = 1'b0;
        ticks(10);

        // START in the DONE cycle is accepted
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        ticks(8);
        op8(8'h80, 8'h01, 1'b1, 16'hFF80, 1'b1);
        ticks(10);

        // Reset on the 4th RUN cycle aborts without a DONE
        op8(8'h12, 8'h34, 1'b0, 16'h0000, 1'b0);
        ticks(3);
        reset_pulse();
        ticks(12);
        op8(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
        ticks(10);

        op16(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);
        ticks(18);
        op16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
        ticks(18);

        for (int i = 0; i < 100 && (q8_res.size() > 0 || q16_res.size() > 0); i++) ticks(1);
        ticks(20);
        fin_chk = 1'b1;
        @(negedge CLK);
        #1;
        fin_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
